serial_uart: RTL and testbench

- Memory-mapped 8N1 UART. Replaces the behavioural serial model behind the IO manager in synthesised builds.
- Same bus-side handshake as the RAM/serial slaves: mode/addr/wdata/rdata, single-cycle access, no wait states.
- RX path feeds a byte FIFO that the CPU monitor polls; TX path uses one holding/shift register.

---
 rtl/serial_uart_if.sv | 12 +
 rtl/serial_uart.sv | 223 ++++++++++++++++++++++
 tb/tb_serial_uart.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_uart_if.sv
// Bus-side handshake shared with the RAM/serial slaves: mode/addr/wdata in, rdata out.
// Zero latency: single-cycle access with no wait states.
// No backpressure: the slave always accepts the access.
interface serial_uart_if;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output mode, output addr, output wdata, input rdata);
    modport slave  (input mode, input addr, input wdata, output rdata);
endinterface

// File: rtl/serial_uart.sv
// Memory-mapped 8N1 UART: DATA/STATUS registers, RX byte FIFO, single TX shift register. Option: SERIAL_UART_LOOPBACK_EN.
// rdata is combinational; RX bytes appear one cycle after the stop-bit mid-sample; a TX frame takes 10*CLK_DIV cycles.
// No bus backpressure: writes while TX is busy are dropped, and RX pushes into a full FIFO are dropped and flag overrun.
module serial_uart #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_uart_if.slave  bus,
    output logic          uart_txd,
    input  logic          uart_rxd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic rd_en, wr_en, sel_data, sel_stat;
    assign rd_en    = (bus.mode == 2'b01);
    assign wr_en    = (bus.mode == 2'b10);
    assign sel_data = (bus.addr[3:2] == 2'b00);
    assign sel_stat = (bus.addr[3:2] == 2'b01);

    logic unused_bits;
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:8]};

    logic txd_q, txd_d;
    logic lb_q;
`ifdef SERIAL_UART_LOOPBACK_EN
    logic lb_d;
    always_comb lb_d = (wr_en && sel_stat) ? bus.wdata[4] : lb_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lb_q <= 1'b0;
        else      lb_q <= lb_d;
    end
`else
    assign lb_q = 1'b0;
`endif

    // Loopback keeps the external line quiet while feeding txd back into RX.
    logic rx_in;
    assign uart_txd = txd_q | lb_q;
    assign rx_in    = lb_q ? txd_q : uart_rxd;

    // ---------------- TX ----------------
    state_t      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_ready;
    assign tx_ready = (tx_state_q == S_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        case (tx_state_q)
            S_IDLE: if (wr_en && sel_data) begin
                tx_state_d = S_START;
                tx_shift_d = bus.wdata[7:0];
                tx_cnt_d   = 16'd0;
                txd_d      = 1'b0;
            end
            S_START: if (tx_cnt_q == DIV_M1) begin
                tx_state_d = S_DATA;
                tx_cnt_d   = 16'd0;
                tx_bit_d   = 3'd0;
                txd_d      = tx_shift_q[0];
                tx_shift_d = tx_shift_q >> 1;
            end else tx_cnt_d = tx_cnt_q + 16'd1;
            S_DATA: if (tx_cnt_q == DIV_M1) begin
                tx_cnt_d = 16'd0;
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = S_STOP;
                    txd_d      = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end
            end else tx_cnt_d = tx_cnt_q + 16'd1;
            S_STOP: if (tx_cnt_q == DIV_M1) begin
                tx_state_d = S_IDLE;
                tx_cnt_d   = 16'd0;
            end else tx_cnt_d = tx_cnt_q + 16'd1;
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    // ---------------- RX ----------------
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    state_t      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_push, fe_set;

    // The counter enters START at 1 so the detection cycle counts toward the half-bit wait.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        fe_set     = 1'b0;
        case (rx_state_q)
            S_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = S_START;
                rx_cnt_d   = 16'd1;
            end
            S_START: if (rx_cnt_q == HALF_M1) begin
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                rx_cnt_d   = 16'd0;
                rx_bit_d   = 3'd0;
            end else rx_cnt_d = rx_cnt_q + 16'd1;
            S_DATA: if (rx_cnt_q == DIV_M1) begin
                rx_cnt_d   = 16'd0;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else rx_cnt_d = rx_cnt_q + 16'd1;
            S_STOP: if (rx_cnt_q == DIV_M1) begin
                rx_state_d = S_IDLE;
                rx_cnt_d   = 16'd0;
                rx_push    = rx_s2_q;
                fe_set     = !rx_s2_q;
            end else rx_cnt_d = rx_cnt_q + 16'd1;
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
        end else begin
            rx_s1_q    <= rx_in;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // ---------------- FIFO and flags ----------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovr_q, ovr_d, fe_q, fe_d;
    logic          empty, full, pop, push_ok, ovr_set, stat_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = rd_en && sel_data && !empty;
    assign push_ok = rx_push && (!full || pop);
    assign ovr_set = rx_push && full && !pop;
    assign stat_rd = rd_en && sel_stat;

    // Flag set takes priority over the clear-on-read.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push_ok) count_d = count_q - CW'(1);
        ovr_d = (stat_rd ? 1'b0 : ovr_q) | ovr_set;
        fe_d  = (stat_rd ? 1'b0 : fe_q) | fe_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            fe_q     <= fe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= rx_shift_q;
    end

    always_comb begin
        bus.rdata = 32'd0;
        if (sel_data && !empty) bus.rdata = {24'd0, mem_q[rd_ptr_q]};
        else if (sel_stat)      bus.rdata = {27'd0, lb_q, fe_q, ovr_q, tx_ready, !empty};
    end
endmodule

// File: tb/tb_serial_uart.sv
// Randomized self-checking bench for serial_uart against a queue-based model of the register map.
// Runs with CLK_DIV=4, FIFO_DEPTH=8; the loopback section builds only with SERIAL_UART_LOOPBACK_EN.
module tb_serial_uart;
    localparam int DIV   = 4;
    localparam int DEPTH = 8;
    localparam logic [31:0] A_DATA = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;

    logic clk = 1'b0;
    logic rst;
    logic uart_rxd;
    logic uart_txd;
    serial_uart_if bus_if();

    serial_uart #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus_if.slave), .uart_txd(uart_txd), .uart_rxd(uart_rxd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit m_ovr = 0, m_fe = 0, m_lb = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {27'd0, m_lb, m_fe, m_ovr, 1'b1, q.size() != 0};
    endfunction

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_if.mode = 2'b01;
        bus_if.addr = a;
        #1 d = bus_if.rdata;
        @(negedge clk);
        bus_if.mode = 2'b00;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] w);
        bus_if.mode  = 2'b10;
        bus_if.addr  = a;
        bus_if.wdata = w;
        @(negedge clk);
        bus_if.mode = 2'b00;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        rd(A_STAT, d);
        chk(tag, d, m_status());
        m_ovr = 0;
        m_fe  = 0;
    endtask

    task automatic check_data(input string tag);
        logic [31:0] d, e;
        rd(A_DATA, d);
        e = (q.size() != 0) ? {24'd0, q.pop_front()} : 32'd0;
        chk(tag, d, e);
    endtask

    // Serial frame on uart_rxd plus the model's view of where the byte ends up.
    task automatic rx_send(input logic [7:0] b, input bit stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        if (!stop_ok)               m_fe = 1;
        else if (q.size() == DEPTH) m_ovr = 1;
        else                        q.push_back(b);
    endtask

    task automatic tx_send_check(input string tag, input logic [7:0] b);
        logic [9:0] f;
        int bad;
        f = {1'b1, b, 1'b0};
        bad = 0;
        wr(A_DATA, {24'd0, b});
        for (int i = 0; i < 10 * DIV; i++) begin
            if (uart_txd !== f[i / DIV]) bad++;
            @(negedge clk);
        end
        chk(tag, bad, 0);
        check_status({tag, "_idle"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [9:0]  wave;
        int          busy, bad;

        bus_if.mode  = 2'b00;
        bus_if.addr  = 32'd0;
        bus_if.wdata = 32'd0;
        uart_rxd     = 1'b1;
        rst          = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'd0, uart_txd}, 32'd1);
        rd(A_STAT, d);
        chk("rst_status", d, 32'h2);
        rst = 1'b1;
        @(negedge clk);
        check_status("status_after_rst");

        // Mid-frame reset aborts TX at once.
        wr(A_DATA, 32'hA5);
        repeat (13) @(negedge clk);
        rst = 1'b0;
        #1 chk("midtx_rst_txd", {31'd0, uart_txd}, 32'd1);
        rd(A_STAT, d);
        chk("midtx_rst_status", d, 32'h2);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 12 * DIV; i++) begin
            if (uart_txd !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("midtx_no_resume", bad, 0);

        // Directed 8'h47 frame with a dropped second write at sample 10.
        wr(A_DATA, 32'h47);
        wave = '0;
        busy = 0;
        bad  = 0;
        for (int i = 0; i < 12 * DIV; i++) begin
            if (i == 10) begin
                bus_if.mode = 2'b10; bus_if.addr = A_DATA; bus_if.wdata = 32'hFF;
            end else begin
                bus_if.mode = 2'b01; bus_if.addr = A_STAT;
            end
            #1;
            if (i < 10 * DIV && (i % DIV) == DIV / 2) wave[i / DIV] = uart_txd;
            if (i >= 10 * DIV && uart_txd !== 1'b1) bad++;
            if (i != 10 && bus_if.rdata[1] == 1'b0) busy++;
            @(negedge clk);
        end
        bus_if.mode = 2'b00;
        chk("tx47_wave", {22'd0, wave}, 32'h28E);
        chk("tx47_busy_reads", busy, 39);
        chk("tx47_second_dropped", bad, 0);
        check_status("tx47_ready");

        // Directed RX of 8'h20.
        rx_send(8'h20, 1'b1);
        check_status("rx20_valid");
        check_data("rx20_data");
        check_status("rx20_empty");

        // Overrun: nine bytes into an eight-deep FIFO.
        for (int k = 1; k <= 9; k++) rx_send(8'(k), 1'b1);
        for (int k = 1; k <= 8; k++) check_data($sformatf("ovr_data%0d", k));
        check_status("ovr_flag_set");
        check_status("ovr_flag_clear");

        // One-cycle glitch must not start a frame.
        uart_rxd = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        check_status("glitch_no_push");
        rx_send(8'hC3, 1'b1);
        check_data("after_glitch_data");

        // Bad stop bit.
        rx_send(8'h5A, 1'b0);
        check_status("frame_err_set");
        check_status("frame_err_clear");

`ifdef SERIAL_UART_LOOPBACK_EN
        wr(A_STAT, 32'h10);
        m_lb = 1;
        check_status("lb_enabled");
        wr(A_DATA, 32'h52);
        bad = 0;
        for (int i = 0; i < 12 * DIV; i++) begin
            if (uart_txd !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("lb_txd_quiet", bad, 0);
        q.push_back(8'h52);
        check_status("lb_rx_valid");
        check_data("lb_data");
        wr(A_STAT, 32'h0);
        m_lb = 0;
        check_status("lb_disabled");
`else
        wr(A_STAT, 32'hFF);
        check_status("status_write_ignored");
`endif

        // Randomized mix of RX frames, reads and TX frames.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: rx_send(8'($urandom), $urandom_range(0, 5) != 0);
                1: check_data($sformatf("rnd_data%0d", n));
                2: check_status($sformatf("rnd_status%0d", n));
                default: tx_send_check($sformatf("rnd_tx%0d", n), 8'($urandom));
            endcase
        end
        while (q.size() != 0) check_data("drain_data");
        check_status("final_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
